// File: rtl/two_bit_dec_unit.sv
// Sequential 2-bit decrement engine: a bank of 2-bit registers, load / decrement-by-k
// commands applied one step per cycle. Optional build macro DEC_SATURATE_EN saturates at 0.
module two_bit_dec_unit #(
    parameter int NREG   = 4,
    parameter int STEP_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_op,
    input  logic [$clog2(NREG)-1:0] cmd_addr,
    input  logic [1:0]              cmd_data,
    input  logic [STEP_W-1:0]       cmd_count,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_data,
    output logic                    rsp_stat
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [NREG-1:0][1:0] bank;
    logic [AW-1:0]       addr;
    logic [STEP_W-1:0]   cnt;
    logic [1:0]          work, work_nx;
    logic                borrow, borrow_nx;
    logic                accept, last_step;

    assign accept    = cmd_valid && cmd_ready;
    assign last_step = (state == STEP) && (cnt == STEP_W'(1));

    // Single decrement step; a step from 0 always records a borrow.
    always_comb begin
        borrow_nx = borrow | (work == 2'd0);
`ifdef DEC_SATURATE_EN
        work_nx = (work == 2'd0) ? 2'd0 : work - 2'd1;
`else
        work_nx = work - 2'd1;
`endif
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nx = (cmd_op && cmd_count != '0) ? STEP : RESP;
            end
            STEP: begin
                if (cnt == STEP_W'(1))
                    state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Bank is touched only on load accept or final step, so partial results never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            addr     <= '0;
            cnt      <= '0;
            work     <= '0;
            borrow   <= 1'b0;
            rsp_data <= '0;
            rsp_stat <= 1'b0;
        end else if (accept) begin
            if (!cmd_op) begin
                bank[cmd_addr] <= cmd_data;
                rsp_data       <= cmd_data;
                rsp_stat       <= 1'b0;
            end else if (cmd_count == '0) begin
                rsp_data <= bank[cmd_addr];
                rsp_stat <= 1'b0;
            end else begin
                addr   <= cmd_addr;
                cnt    <= cmd_count;
                work   <= bank[cmd_addr];
                borrow <= 1'b0;
            end
        end else if (state == STEP) begin
            work   <= work_nx;
            borrow <= borrow_nx;
            cnt    <= cnt - STEP_W'(1);
            if (last_step) begin
                bank[addr] <= work_nx;
                rsp_data   <= work_nx;
                rsp_stat   <= borrow_nx;
            end
        end
    end

endmodule
